approx_mult_seq_ctrl: RTL

//  Sequential controller for a configurable-accuracy 8x8 multiply built from one shared 4x4 multiplier.

---
 rtl/approx_mult_pkg.sv | 27 ++
 rtl/lm4x4_lvl.sv | 15 +
 rtl/approx_mult_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the sequential approximate 8x8 multiplier.
// Contents: FSM state enum, level width, per-quadrant shift table, level mask helper.
package approx_mult_pkg;

  localparam int unsigned LVL_W  = 2;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OPND_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q0   = 3'd1,
    Q1   = 3'd2,
    Q2   = 3'd3,
    Q3   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Left shift applied to each quadrant's sub-product, indexed by quadrant 0..3.
  localparam logic [3:0] QUAD_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  // Mask that clears the k least-significant bits of an 8-bit sub-product.
  function automatic logic [7:0] level_mask(input logic [LVL_W-1:0] k);
    return 8'hFF << k;
  endfunction

endpackage

// File: rtl/lm4x4_lvl.sv
// Combinational 4x4 multiplier with selectable accuracy level.
// Ports: a[3:0], b[3:0] nibble operands; lvl[1:0] number of product LSBs
//        forced to zero (0 = exact); p[7:0] resulting sub-product.
module lm4x4_lvl
  import approx_mult_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic [LVL_W-1:0] lvl,
  output logic [7:0]       p
);

  assign p = (8'(a) * 8'(b)) & level_mask(lvl);

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequential controller for a configurable-accuracy 8x8 multiply built on one
// shared 4x4 multiplier. Operands are accepted over valid/ready, the four
// nibble partial products are issued in states Q0..Q3 and shift-accumulated,
// and the 16-bit product is offered over valid/ready.
// Ports: clk, rst (async active-high); in_valid/in_ready, a, b, cfg_level
//        (operand side); out_valid/out_ready, r (result side); busy (not IDLE).
// Optional: APPROX_MULT_PERF_CNT_EN adds op_cnt and approx_cnt outputs.
module approx_mult_seq_ctrl
  import approx_mult_pkg::*;
#(
  parameter logic [7:0] CFG_RST   = 8'h00,
  parameter bit         SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [7:0]        cfg_level,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] r,
  output logic              busy
`ifdef APPROX_MULT_PERF_CNT_EN
  ,
  output logic [15:0]       op_cnt,
  output logic [15:0]       approx_cnt
`endif
);

  state_t              state, state_nxt;
  logic [OPND_W-1:0]   a_q, b_q;
  logic [7:0]          lvl_q;
  logic [PROD_W-1:0]   acc;
  logic [1:0]          quad;
  logic                quad_en;
  logic                accept;
  logic                zero_op;
  logic [NIB_W-1:0]    nib_a, nib_b;
  logic [LVL_W-1:0]    lvl_sel;
  logic [7:0]          sub;
  logic [PROD_W-1:0]   addend;

  assign accept  = in_valid && in_ready;
  assign zero_op = SKIP_ZERO && ((a == 8'd0) || (b == 8'd0));

  // Next-state and quadrant selection.
  always_comb begin
    state_nxt = state;
    quad      = 2'd0;
    quad_en   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? DONE : Q0;
      Q0: begin quad = 2'd0; quad_en = 1'b1; state_nxt = Q1;   end
      Q1: begin quad = 2'd1; quad_en = 1'b1; state_nxt = Q2;   end
      Q2: begin quad = 2'd2; quad_en = 1'b1; state_nxt = Q3;   end
      Q3: begin quad = 2'd3; quad_en = 1'b1; state_nxt = DONE; end
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Nibble mux: quad[1] picks the high nibble of a, quad[0] the high nibble of b.
  assign nib_a   = quad[1] ? a_q[7:4] : a_q[3:0];
  assign nib_b   = quad[0] ? b_q[7:4] : b_q[3:0];
  assign lvl_sel = lvl_q[{quad, 1'b0} +: LVL_W];

  lm4x4_lvl u_mul (
    .a   (nib_a),
    .b   (nib_b),
    .lvl (lvl_sel),
    .p   (sub)
  );

  assign addend = PROD_W'(sub) << QUAD_SHIFT[quad];

  // State, operand capture, accumulator and result handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      r         <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      lvl_q     <= CFG_RST;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);
      busy     <= (state_nxt != IDLE);
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        lvl_q <= cfg_level;
        acc   <= '0;
      end else if (quad_en) begin
        acc <= acc + addend;
      end
      // r is loaded from the settled accumulator on the first DONE cycle.
      if ((state == DONE) && !out_valid) begin
        out_valid <= 1'b1;
        r         <= acc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef APPROX_MULT_PERF_CNT_EN
  // Completed-handshake counters; both wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt     <= '0;
      approx_cnt <= '0;
    end else if (out_valid && out_ready) begin
      op_cnt <= op_cnt + 16'd1;
      if (lvl_q != 8'd0) approx_cnt <= approx_cnt + 16'd1;
    end
  end
`endif

endmodule
